// File: rtl/ic_ram_seq.sv
// Waveform RAM sequencer: streams load data into the dual-port RAM and plays it back
// in loops through a small credit-controlled output FIFO.
module ic_ram_seq #(
    parameter int RAM_DW = 128,
    parameter int RAM_AW = 9,
    parameter int RD_LAT = 1,
    parameter int LOOP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_load,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic [RAM_AW-1:0] cfg_last_addr,
    input  logic [LOOP_W-1:0] cfg_loops,
    input  logic [RAM_DW-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [RAM_DW-1:0] ram_wdata,
    output logic [RAM_AW-1:0] ram_raddr,
    input  logic [RAM_DW-1:0] ram_rdata,
    output logic [RAM_DW-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [LOOP_W-1:0] loop_idx
);
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [RAM_AW-1:0] wptr_reg, wptr_next, rptr_reg, rptr_next;
    logic [RAM_AW-1:0] last_reg, last_next;
    logic [LOOP_W-1:0] loops_reg, loops_next, loop_idx_reg, loop_idx_next;
    logic              s_ready_reg, s_ready_next, we_reg, we_next, done_reg, done_next;
    logic [RAM_AW-1:0] waddr_reg, waddr_next, raddr_reg, raddr_next;
    logic [RAM_DW-1:0] wdata_reg, wdata_next;
    logic [2:0]        inflight_reg, inflight_next;
    logic [RD_LAT:0]   rd_vld_reg;
    logic              issue;

    logic [RAM_DW-1:0] fifo_mem_reg [FIFO_DEPTH];
    logic [1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [2:0]        count_reg;
    logic [FIFO_DEPTH-1:0] fifo_wen;
    logic              push, pop, credit;

    logic [RAM_AW-1:0] iss_ptr, iss_last;
    logic [LOOP_W-1:0] iss_loops, iss_idx, idx_inc;

    // A read is tracked from issue until its data lands in the FIFO RD_LAT+1 edges later.
    assign push   = rd_vld_reg[RD_LAT];
    assign pop    = (count_reg != 3'd0) && m_ready;
    // Counting this cycle's pop frees a slot early enough to sustain one word per cycle.
    assign credit = ({1'b0, count_reg} + {1'b0, inflight_reg} - {3'b000, pop}) < 4'd4;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wen
        assign fifo_wen[gi] = push && (wr_ptr_reg == 2'(gi));
    end

    always_comb begin
        state_next    = state_reg;
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        last_next     = last_reg;
        loops_next    = loops_reg;
        loop_idx_next = loop_idx_reg;
        s_ready_next  = s_ready_reg;
        we_next       = 1'b0;
        done_next     = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        raddr_next    = raddr_reg;
        issue         = 1'b0;
        // The first read is issued in the accepting cycle, so IDLE supplies fresh values.
        iss_ptr   = (state_reg == IDLE) ? '0 : rptr_reg;
        iss_last  = (state_reg == IDLE) ? cfg_last_addr : last_reg;
        iss_loops = (state_reg == IDLE) ? cfg_loops : loops_reg;
        iss_idx   = (state_reg == IDLE) ? '0 : loop_idx_reg;
        idx_inc   = iss_idx + LOOP_W'(1);

        case (state_reg)
            IDLE: begin
                if (!cmd_stop) begin
                    if (cmd_load) begin
                        state_next   = LOAD;
                        wptr_next    = '0;
                        last_next    = cfg_last_addr;
                        loops_next   = cfg_loops;
                        s_ready_next = 1'b1;
                    end else if (cmd_play) begin
                        state_next = PLAY;
                        last_next  = cfg_last_addr;
                        loops_next = cfg_loops;
                        issue      = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_valid && s_ready_reg) begin
                    we_next    = 1'b1;
                    waddr_next = wptr_reg;
                    wdata_next = s_data;
                    wptr_next  = wptr_reg + RAM_AW'(1);
                    if (wptr_reg == last_reg) begin
                        s_ready_next = 1'b0;
                        state_next   = IDLE;
                        done_next    = 1'b1;
                    end
                end
                if (cmd_stop) begin
                    s_ready_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            PLAY: begin
                issue = credit;
                if (cmd_stop) state_next = DRAIN;
            end
            DRAIN: begin
                if (inflight_reg == 3'd0 && count_reg == 3'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue) begin
            raddr_next = iss_ptr;
            if (iss_ptr == iss_last) begin
                rptr_next     = '0;
                loop_idx_next = idx_inc;
                if (iss_loops != '0 && idx_inc == iss_loops) state_next = DRAIN;
            end else begin
                rptr_next     = iss_ptr + RAM_AW'(1);
                loop_idx_next = iss_idx;
            end
        end

        inflight_next = inflight_reg + {2'b00, issue} - {2'b00, push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            last_reg     <= '0;
            loops_reg    <= '0;
            loop_idx_reg <= '0;
            s_ready_reg  <= 1'b0;
            we_reg       <= 1'b0;
            done_reg     <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            raddr_reg    <= '0;
            inflight_reg <= '0;
            rd_vld_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            last_reg     <= last_next;
            loops_reg    <= loops_next;
            loop_idx_reg <= loop_idx_next;
            s_ready_reg  <= s_ready_next;
            we_reg       <= we_next;
            done_reg     <= done_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            raddr_reg    <= raddr_next;
            inflight_reg <= inflight_next;
            rd_vld_reg   <= {rd_vld_reg[RD_LAT-1:0], issue};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (fifo_wen[i]) fifo_mem_reg[i] <= ram_rdata;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_reg == 3'd4));

    assign s_ready   = s_ready_reg;
    assign ram_we    = we_reg;
    assign ram_waddr = waddr_reg;
    assign ram_wdata = wdata_reg;
    assign ram_raddr = raddr_reg;
    assign m_valid   = (count_reg != 3'd0);
    assign m_data    = fifo_mem_reg[rd_ptr_reg];
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign loop_idx  = loop_idx_reg;
endmodule

// File: doc/ic_ram_seq.md
Name: ic_ram_seq

Overview:
- Single-clock sequencer that owns both ports of the 128-bit x 512 waveform dual-port RAM.
- LOAD mode: accepts a valid/ready sample-word stream from the host/DMA side and writes it to consecutive RAM addresses.
- PLAY mode: reads the stored waveform repeatedly, from address 0 to a programmed last address, for a programmed loop count.
- Read data goes through a credit-controlled 4-entry output FIFO toward the DAC datapath.

Parameters:
RAM_DW, 128, RAM data width (bits)
RAM_AW, 9, RAM address width
RD_LAT, 1, RAM read latency in cycles from ram_raddr to valid ram_rdata (legal: 1 or 2)
LOOP_W, 16, loop counter width

Ports:
clk  in  1  single clock; drives both RAM ports (clka = clkb = clk)
rst_n  in  1  reset, asynchronous, active-low
cmd_load  in  1  pulse: start load
cmd_play  in  1  pulse: start playback
cmd_stop  in  1  pulse: abort load / end playback
cfg_last_addr  in  RAM_AW  last RAM address used (length = value + 1)
cfg_loops  in  LOOP_W  number of passes; 0 = infinite
s_data  in  RAM_DW  load stream data
s_valid  in  1  load stream valid
s_ready  out  1  load stream ready
ram_we  out  1  RAM write enable
ram_waddr  out  RAM_AW  RAM write address
ram_wdata  out  RAM_DW  RAM write data
ram_raddr  out  RAM_AW  RAM read address
ram_rdata  in  RAM_DW  RAM read data
m_data  out  RAM_DW  playback data
m_valid  out  1  playback valid
m_ready  in  1  playback ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when LOAD or DRAIN completes
loop_idx  out  LOOP_W  completed passes in the current playback

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - s_ready, ram_we, m_valid, busy, done = 0.
  - ram_waddr, ram_raddr, ram_wdata, m_data, loop_idx = 0.
  - FIFO empty; in-flight count = 0.
- Reset asserted mid-operation: abandons everything immediately. No further RAM writes; FIFO contents are discarded.
- States: IDLE, LOAD, PLAY, DRAIN. Command priority in IDLE: cmd_stop (ignored) > cmd_load > cmd_play.
- Command handling: cfg_last_addr and cfg_loops are latched on command acceptance. Commands in other states are ignored except cmd_stop.
- IDLE->LOAD: write pointer = 0; s_ready=1 from the next cycle.
- LOAD:
  - Each s_valid&&s_ready handshake registers ram_we=1, ram_waddr=ptr, ram_wdata=s_data one cycle later, then increments ptr.
  - The handshake at ptr==last drops s_ready in the following cycle and transitions to IDLE. done pulses in the cycle of that final ram_we.
  - cmd_stop: goes to IDLE next cycle with s_ready=0. A handshake in the same cycle as cmd_stop is still written. No done pulse.
- IDLE->PLAY: read pointer = 0, loop_idx = 0.
- PLAY, read issue:
  - Issue a read (drive ram_raddr=ptr, registered) only when fifo_count + inflight < 4.
  - Issued data enters the FIFO exactly RD_LAT cycles after ram_raddr updates.
  - Pointer wraps from last to 0; loop_idx increments on the wrap.
- PLAY -> DRAIN:
  - When cfg_loops != 0 and the wrap makes loop_idx == cfg_loops, stop issuing and go to DRAIN.
  - cmd_stop also goes to DRAIN; reads already issued are still delivered.
  - If cmd_stop and a final wrap occur in the same cycle, loop_idx still increments.
- DRAIN: no new reads. When inflight==0 and the FIFO is empty, go to IDLE with a done pulse.
- Output: m_valid = FIFO non-empty; m_data = FIFO head, held stable while m_valid && !m_ready.
- Throughput: one word/cycle sustained with m_ready=1 and RD_LAT ≤ 2. The FIFO never overflows; overflow is an assertion failure.
- First-word latency after cmd_play: m_valid rises RD_LAT+2 cycles after the cmd_play cycle.
- cfg_last_addr=0: a one-word waveform, each word is one pass.
- Width rules: loop_idx is LOOP_W-bit. With cfg_loops=0 it wraps silently at 2^LOOP_W.

Test Plan:
- Load: cfg_last_addr=7, stream 0..7 with s_valid toggling 50% -> exactly 8 ram_we at addrs 0..7 with matching data; done pulses once; s_ready=0 afterward.
- Playback: cfg_last_addr=3, cfg_loops=2, m_ready=1, RD_LAT=1 and 2 -> m_data sequence A0..A3,A0..A3 back-to-back with no bubbles; loop_idx ends 2; done pulses once; busy drops.
- Backpressure: same as the playback case with m_ready random 30% -> identical sequence; no FIFO overflow; m_data stable while stalled.
- Stop: cfg_loops=0, cmd_stop at cycle 20 -> in-flight words still delivered, no further ram_raddr changes, then IDLE + done.
- Edge: cfg_last_addr=0, cfg_loops=3 -> exactly three copies of word 0.
- Reset mid-LOAD: rst_n low at ptr=5 -> all outputs at reset values asynchronously; no ram_we after reset.
- Reset mid-PLAY: rst_n low -> all outputs at reset values asynchronously; FIFO emptied.
